// File: rtl/pcss_pkg.sv
// Shared constants, packet field codes and types for the PCSS chip top.
package pcss_pkg;

  localparam int PKT_W      = 60;  // full packet width (flit payload + connection bit)
  localparam int FLIT_W     = 16;  // link flit width
  localparam int NFLIT      = 4;   // flits per packet
  localparam int NLINK      = 4;   // E, N, W, S
  localparam int FIFO_DEPTH = 4;   // outbound spikes buffered per link

  typedef enum logic [1:0] {
    PT_CFG   = 2'b00,
    PT_SPIKE = 2'b01,
    PT_RSV2  = 2'b10,
    PT_RSV3  = 2'b11
  } ptype_e;

  typedef enum logic [1:0] {
    PORT_E = 2'd0,
    PORT_N = 2'd1,
    PORT_W = 2'd2,
    PORT_S = 2'd3
  } port_e;

  typedef struct packed {
    logic        en;
    port_e       port;
    logic [15:0] dst;
  } route_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,  // nothing releasable
    TX_VALID = 2'd1,  // flit driven, waiting for peer ready
    TX_WAIT  = 2'd2,  // flit answered, waiting for peer ready to drop
    TX_DONE  = 2'd3   // last flit answered, waiting for peer ready to drop
  } tx_state_e;

  // Flit idx of a packet; f0 carries the top 12 bits zero-extended.
  function automatic logic [FLIT_W-1:0] pkt_flit(input logic [PKT_W-1:0] pkt,
                                                 input logic [1:0] idx);
    logic [FLIT_W-1:0] flit;
    case (idx)
      2'd0:    flit = {4'b0000, pkt[59:48]};
      2'd1:    flit = pkt[47:32];
      2'd2:    flit = pkt[31:16];
      default: flit = pkt[15:0];
    endcase
    return flit;
  endfunction

endpackage

// File: rtl/pcss_link.sv
// One PCSS link: 4-phase flit receiver with packet holding register,
// 4-deep outbound spike FIFO gated by timestep release, and 4-phase transmitter.
module pcss_link
  import pcss_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] i_recv_data,
  input  logic              i_recv_valid,
  input  logic              i_recv_par,
  output logic              o_recv_ready,
  output logic              o_recv_err,
  output logic [PKT_W-1:0]  o_rx_pkt,
  output logic              o_rx_full,
  input  logic              i_rx_take,
  input  logic              i_push,
  input  logic [PKT_W-1:0]  i_push_pkt,
  output logic              o_fifo_full,
  input  logic              i_tik_edge,
  output logic [FLIT_W-1:0] o_send_data,
  output logic              o_send_valid,
  output logic              o_send_par,
  input  logic              i_send_ready,
  input  logic              i_send_err
);

  logic             r_rx_ready;
  logic             r_rx_err;
  logic [1:0]       r_rx_cnt;
  logic             r_rx_bad;
  logic             r_rx_full;
  logic [PKT_W-1:0] r_rx_pkt;
  logic             w_par_bad;

  logic [PKT_W-1:0] r_fifo [FIFO_DEPTH];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [2:0]       r_count;
  logic [2:0]       r_rel;     // entries at the head that may be transmitted
  logic             w_pop;

  tx_state_e        r_tx_state;
  tx_state_e        w_tx_state_next;
  logic [1:0]       r_tx_cnt;
  logic [1:0]       w_tx_cnt_next;
  logic [FLIT_W-1:0] w_flit;

  assign w_par_bad = i_recv_par ^ (^i_recv_data);

  // Receiver: ack one flit per 4-phase cycle, assemble the packet, drop it if any flit was corrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_ready <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_cnt   <= 2'd0;
      r_rx_bad   <= 1'b0;
      r_rx_full  <= 1'b0;
      r_rx_pkt   <= '0;
    end else begin
      if (i_rx_take) r_rx_full <= 1'b0;
      if (!r_rx_ready) begin
        // A held packet blocks the next f0 until the arbiter consumes it.
        if (i_recv_valid && !r_rx_full) begin
          r_rx_ready <= 1'b1;
          r_rx_err   <= w_par_bad;
          r_rx_cnt   <= r_rx_cnt + 2'd1;
          case (r_rx_cnt)
            2'd0:    r_rx_pkt[59:48] <= i_recv_data[11:0];
            2'd1:    r_rx_pkt[47:32] <= i_recv_data;
            2'd2:    r_rx_pkt[31:16] <= i_recv_data;
            default: r_rx_pkt[15:0]  <= i_recv_data;
          endcase
          if (r_rx_cnt == 2'd0) r_rx_bad <= w_par_bad;
          else                  r_rx_bad <= r_rx_bad | w_par_bad;
          if (r_rx_cnt == 2'(NFLIT - 1)) r_rx_full <= ~(r_rx_bad | w_par_bad);
        end
      end else if (!i_recv_valid) begin
        r_rx_ready <= 1'b0;
        r_rx_err   <= 1'b0;
      end
    end
  end

  assign o_recv_ready = r_rx_ready;
  assign o_recv_err   = r_rx_err;
  assign o_rx_pkt     = r_rx_pkt;
  assign o_rx_full    = r_rx_full;

  // FIFO storage: plain write port, no reset needed on the data.
  always_ff @(posedge clk) begin
    if (i_push) r_fifo[r_wr_ptr] <= i_push_pkt;
  end

  // FIFO pointers, occupancy and the releasable count captured at each timestep edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      r_rel    <= 3'd0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + {2'b00, i_push} - {2'b00, w_pop};
      // A push landing on the edge cycle waits for the following edge.
      if (i_tik_edge) r_rel <= r_count - {2'b00, w_pop};
      else            r_rel <= r_rel - {2'b00, w_pop};
    end
  end

  assign o_fifo_full = (r_count == 3'(FIFO_DEPTH));

  // Transmitter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 2'd0;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
    end
  end

  // Transmitter next state: a peer error keeps the flit index so the same flit is resent.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_pop           = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (r_rel != 3'd0) begin
          w_tx_state_next = TX_VALID;
          w_tx_cnt_next   = 2'd0;
        end
      end
      TX_VALID: begin
        if (i_send_ready) begin
          w_tx_state_next = TX_WAIT;
          if (!i_send_err) begin
            if (r_tx_cnt == 2'(NFLIT - 1)) begin
              w_pop           = 1'b1;
              w_tx_state_next = TX_DONE;
              w_tx_cnt_next   = 2'd0;
            end else begin
              w_tx_cnt_next = r_tx_cnt + 2'd1;
            end
          end
        end
      end
      TX_WAIT: if (!i_send_ready) w_tx_state_next = TX_VALID;
      TX_DONE: if (!i_send_ready) w_tx_state_next = TX_IDLE;
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  assign w_flit       = pkt_flit(r_fifo[r_rd_ptr], r_tx_cnt);
  assign o_send_valid = (r_tx_state == TX_VALID);
  assign o_send_data  = o_send_valid ? w_flit : '0;
  assign o_send_par   = ^o_send_data;

endmodule

// File: rtl/pcss_chip_top.sv
// PCSS chip top: four links, route table, round-robin packet consumer, tik synchroniser.
module pcss_chip_top
  import pcss_pkg::*;
#(
  parameter int FW             = 59,
  parameter int B              = 4,
  parameter int CONNECT        = 2,
  parameter int P_MESH         = 5,
  parameter int P_HIER         = 7,
  parameter int CHIPDATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tik,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in_E,
  input  logic                      recv_data_valid_E,
  input  logic                      recv_data_par_E,
  output logic                      recv_data_ready_E,
  output logic                      recv_data_err_E,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out_E,
  output logic                      send_data_valid_E,
  output logic                      send_data_par_E,
  input  logic                      send_data_ready_E,
  input  logic                      send_data_err_E,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in_N,
  input  logic                      recv_data_valid_N,
  input  logic                      recv_data_par_N,
  output logic                      recv_data_ready_N,
  output logic                      recv_data_err_N,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out_N,
  output logic                      send_data_valid_N,
  output logic                      send_data_par_N,
  input  logic                      send_data_ready_N,
  input  logic                      send_data_err_N,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in_W,
  input  logic                      recv_data_valid_W,
  input  logic                      recv_data_par_W,
  output logic                      recv_data_ready_W,
  output logic                      recv_data_err_W,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out_W,
  output logic                      send_data_valid_W,
  output logic                      send_data_par_W,
  input  logic                      send_data_ready_W,
  input  logic                      send_data_err_W,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in_S,
  input  logic                      recv_data_valid_S,
  input  logic                      recv_data_par_S,
  output logic                      recv_data_ready_S,
  output logic                      recv_data_err_S,
  output logic [CHIPDATA_WIDTH-1:0] send_data_out_S,
  output logic                      send_data_valid_S,
  output logic                      send_data_par_S,
  input  logic                      send_data_ready_S,
  input  logic                      send_data_err_S
);

  localparam int PW = FW + $clog2(CONNECT);

  // Router port counts only matter to the surrounding fabric.
  logic w_unused_params;
  assign w_unused_params = ^{P_MESH[0], P_HIER[0], PW[0]};

  logic [CHIPDATA_WIDTH-1:0] w_recv_data [NLINK];
  logic [CHIPDATA_WIDTH-1:0] w_send_data [NLINK];
  logic [NLINK-1:0] w_recv_valid, w_recv_par, w_recv_ready, w_recv_err;
  logic [NLINK-1:0] w_send_valid, w_send_par, w_send_ready, w_send_err;
  logic [NLINK-1:0] w_rx_full, w_take, w_push, w_fifo_full;
  logic [PKT_W-1:0] w_rx_pkt [NLINK];
  logic [PKT_W-1:0] w_pkt;
  logic [PKT_W-1:0] w_push_pkt;

  route_t     r_route [2**B];
  route_t     w_entry;
  logic [1:0] r_rr;
  logic [1:0] w_sel;
  logic       w_any;
  logic       w_cfg_we;
  logic       r_tik_meta, r_tik_sync, r_tik_prev;
  logic       w_tik_edge;

  assign w_recv_data[0] = recv_data_in_E;
  assign w_recv_data[1] = recv_data_in_N;
  assign w_recv_data[2] = recv_data_in_W;
  assign w_recv_data[3] = recv_data_in_S;
  assign w_recv_valid   = {recv_data_valid_S, recv_data_valid_W, recv_data_valid_N, recv_data_valid_E};
  assign w_recv_par     = {recv_data_par_S, recv_data_par_W, recv_data_par_N, recv_data_par_E};
  assign w_send_ready   = {send_data_ready_S, send_data_ready_W, send_data_ready_N, send_data_ready_E};
  assign w_send_err     = {send_data_err_S, send_data_err_W, send_data_err_N, send_data_err_E};
  assign {recv_data_ready_S, recv_data_ready_W, recv_data_ready_N, recv_data_ready_E} = w_recv_ready;
  assign {recv_data_err_S, recv_data_err_W, recv_data_err_N, recv_data_err_E}         = w_recv_err;
  assign {send_data_valid_S, send_data_valid_W, send_data_valid_N, send_data_valid_E} = w_send_valid;
  assign {send_data_par_S, send_data_par_W, send_data_par_N, send_data_par_E}         = w_send_par;
  assign send_data_out_E = w_send_data[0];
  assign send_data_out_N = w_send_data[1];
  assign send_data_out_W = w_send_data[2];
  assign send_data_out_S = w_send_data[3];

  generate
    for (genvar gi = 0; gi < NLINK; gi++) begin : g_link
      pcss_link u_link (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_recv_data  (w_recv_data[gi]),
        .i_recv_valid (w_recv_valid[gi]),
        .i_recv_par   (w_recv_par[gi]),
        .o_recv_ready (w_recv_ready[gi]),
        .o_recv_err   (w_recv_err[gi]),
        .o_rx_pkt     (w_rx_pkt[gi]),
        .o_rx_full    (w_rx_full[gi]),
        .i_rx_take    (w_take[gi]),
        .i_push       (w_push[gi]),
        .i_push_pkt   (w_push_pkt),
        .o_fifo_full  (w_fifo_full[gi]),
        .i_tik_edge   (w_tik_edge),
        .o_send_data  (w_send_data[gi]),
        .o_send_valid (w_send_valid[gi]),
        .o_send_par   (w_send_par[gi]),
        .i_send_ready (w_send_ready[gi]),
        .i_send_err   (w_send_err[gi])
      );
    end
  endgenerate

  // Two-flop tik synchroniser plus a history flop; any change is a timestep boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tik_meta <= 1'b0;
      r_tik_sync <= 1'b0;
      r_tik_prev <= 1'b0;
    end else begin
      r_tik_meta <= tik;
      r_tik_sync <= r_tik_meta;
      r_tik_prev <= r_tik_sync;
    end
  end
  assign w_tik_edge = r_tik_sync ^ r_tik_prev;

  // Pick the first holding receiver at or after the round-robin pointer, then decode its packet.
  always_comb begin
    logic [1:0] v_idx;
    v_idx    = 2'd0;
    w_sel    = r_rr;
    w_any    = 1'b0;
    for (int k = NLINK - 1; k >= 0; k--) begin
      v_idx = r_rr + 2'(k);
      if (w_rx_full[v_idx]) begin
        w_sel = v_idx;
        w_any = 1'b1;
      end
    end
    w_pkt      = w_rx_pkt[w_sel];
    w_entry    = r_route[w_pkt[57 -: B]];
    w_push_pkt = {w_pkt[59:16], w_entry.dst};
    w_take     = '0;
    w_push     = '0;
    w_cfg_we   = 1'b0;
    if (w_any) begin
      case (w_pkt[59:58])
        PT_CFG: begin
          w_cfg_we      = 1'b1;
          w_take[w_sel] = 1'b1;
        end
        PT_SPIKE: begin
          if (!w_entry.en) begin
            w_take[w_sel] = 1'b1;
          end else if (!w_fifo_full[w_entry.port]) begin
            // Full FIFO leaves the packet in its receiver for a later retry.
            w_push[w_entry.port] = 1'b1;
            w_take[w_sel]        = 1'b1;
          end
        end
        default: w_take[w_sel] = 1'b1;
      endcase
    end
  end

  // Route table writes from config packets; pointer moves past every receiver offered a turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**B; i++) r_route[i] <= '0;
      r_rr <= 2'd0;
    end else begin
      if (w_cfg_we) begin
        r_route[w_pkt[57 -: B]] <= '{en: w_pkt[53], port: port_e'(w_pkt[52:51]), dst: w_pkt[15:0]};
      end
      if (w_any) r_rr <= w_sel + 2'd1;
    end
  end

endmodule

// File: tb/tb_pcss_chip_top.sv
// Directed bench for pcss_chip_top; link index 0=E, 1=N, 2=W, 3=S.
module tb_pcss_chip_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tik;
  logic [15:0] in_data  [4];
  logic        in_valid [4];
  logic        in_par   [4];
  logic        in_ready [4];
  logic        in_err   [4];
  logic [15:0] out_data [4];
  logic        out_valid[4];
  logic        out_par  [4];
  logic        out_ready[4];
  logic        out_err  [4];

  int n_checks = 0;
  int n_errors = 0;

  pcss_chip_top dut (
    .clk(clk), .rst_n(rst_n), .tik(tik),
    .recv_data_in_E(in_data[0]), .recv_data_valid_E(in_valid[0]), .recv_data_par_E(in_par[0]),
    .recv_data_ready_E(in_ready[0]), .recv_data_err_E(in_err[0]),
    .send_data_out_E(out_data[0]), .send_data_valid_E(out_valid[0]), .send_data_par_E(out_par[0]),
    .send_data_ready_E(out_ready[0]), .send_data_err_E(out_err[0]),
    .recv_data_in_N(in_data[1]), .recv_data_valid_N(in_valid[1]), .recv_data_par_N(in_par[1]),
    .recv_data_ready_N(in_ready[1]), .recv_data_err_N(in_err[1]),
    .send_data_out_N(out_data[1]), .send_data_valid_N(out_valid[1]), .send_data_par_N(out_par[1]),
    .send_data_ready_N(out_ready[1]), .send_data_err_N(out_err[1]),
    .recv_data_in_W(in_data[2]), .recv_data_valid_W(in_valid[2]), .recv_data_par_W(in_par[2]),
    .recv_data_ready_W(in_ready[2]), .recv_data_err_W(in_err[2]),
    .send_data_out_W(out_data[2]), .send_data_valid_W(out_valid[2]), .send_data_par_W(out_par[2]),
    .send_data_ready_W(out_ready[2]), .send_data_err_W(out_err[2]),
    .recv_data_in_S(in_data[3]), .recv_data_valid_S(in_valid[3]), .recv_data_par_S(in_par[3]),
    .recv_data_ready_S(in_ready[3]), .recv_data_err_S(in_err[3]),
    .send_data_out_S(out_data[3]), .send_data_valid_S(out_valid[3]), .send_data_par_S(out_par[3]),
    .send_data_ready_S(out_ready[3]), .send_data_err_S(out_err[3])
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] flit_of(input logic [59:0] pkt, input int f);
    logic [15:0] r;
    case (f)
      0:       r = {4'b0000, pkt[59:48]};
      1:       r = pkt[47:32];
      2:       r = pkt[31:16];
      default: r = pkt[15:0];
    endcase
    return r;
  endfunction

  function automatic logic [59:0] cfg_pkt(input logic [3:0] idx, input logic en,
                                          input logic [1:0] port, input logic [15:0] dst);
    return {2'b00, idx, en, port, 35'h0, dst};
  endfunction

  function automatic logic [59:0] spike_pkt(input logic [3:0] idx, input logic [37:0] body,
                                            input logic [15:0] low);
    return {2'b01, idx, body, low};
  endfunction

  task automatic wait_in_ready(input int l, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready[l] === lvl) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_out_valid(input int l, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid[l] === lvl) begin ok = 1'b1; break; end
    end
  endtask

  // Drive one packet into link l; flit 'bad' (or -1) gets inverted parity.
  task automatic send_pkt(input int l, input logic [59:0] pkt, input int bad);
    bit ok;
    logic [15:0] fl;
    for (int f = 0; f < 4; f++) begin
      fl = flit_of(pkt, f);
      in_data[l]  = fl;
      in_par[l]   = (^fl) ^ (f == bad);
      in_valid[l] = 1'b1;
      wait_in_ready(l, 1'b1, ok);
      check_val($sformatf("rx_ack l%0d f%0d", l, f), 64'(ok), 64'd1);
      check_val($sformatf("rx_err l%0d f%0d", l, f), 64'(in_err[l]), 64'(f == bad));
      in_valid[l] = 1'b0;
      wait_in_ready(l, 1'b0, ok);
      check_val($sformatf("rx_release l%0d f%0d", l, f), 64'(ok), 64'd1);
    end
  endtask

  // Sink one packet from link l; flit 'errf' (or -1) is answered with err once.
  task automatic recv_pkt(input int l, input int errf, output logic [59:0] pkt);
    bit ok;
    logic [15:0] fl [4];
    for (int f = 0; f < 4; f++) begin
      wait_out_valid(l, 1'b1, ok);
      check_val($sformatf("tx_valid l%0d f%0d", l, f), 64'(ok), 64'd1);
      fl[f] = out_data[l];
      check_val($sformatf("tx_par l%0d f%0d", l, f), 64'(out_par[l]), 64'(^out_data[l]));
      if (f == errf) begin
        out_err[l]   = 1'b1;
        out_ready[l] = 1'b1;
        wait_out_valid(l, 1'b0, ok);
        out_ready[l] = 1'b0;
        out_err[l]   = 1'b0;
        wait_out_valid(l, 1'b1, ok);
        check_val($sformatf("tx_resend l%0d f%0d", l, f), 64'(out_data[l]), 64'(fl[f]));
      end
      out_ready[l] = 1'b1;
      wait_out_valid(l, 1'b0, ok);
      check_val($sformatf("tx_drop l%0d f%0d", l, f), 64'(ok), 64'd1);
      out_ready[l] = 1'b0;
    end
    check_val($sformatf("tx_f0_pad l%0d", l), 64'(fl[0][15:12]), 64'd0);
    pkt = {fl[0][11:0], fl[1], fl[2], fl[3]};
  endtask

  task automatic tik_step();
    repeat (3) @(negedge clk);
    tik = ~tik;
    repeat (5) @(negedge clk);
  endtask

  task automatic quiet_count(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (out_valid[k]) cnt++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [59:0] sp, sp2, got, got2, pa, pb;
    logic [59:0] five [5];
    int cnt;
    rst_n = 1'b0;
    tik   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_data[k] = '0; in_valid[k] = 1'b0; in_par[k] = 1'b0;
      out_ready[k] = 1'b0; out_err[k] = 1'b0;
    end
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("rst_ready l%0d", k), 64'(in_ready[k]), 64'd0);
      check_val($sformatf("rst_rxerr l%0d", k), 64'(in_err[k]), 64'd0);
      check_val($sformatf("rst_valid l%0d", k), 64'(out_valid[k]), 64'd0);
      check_val($sformatf("rst_data l%0d", k), 64'({out_par[k], out_data[k]}), 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Config idx3 -> E, dst 0x1234; spike idx3 held until tik edge.
    send_pkt(0, cfg_pkt(4'd3, 1'b1, 2'd0, 16'h1234), -1);
    sp = spike_pkt(4'd3, 38'h12_3456_789A, 16'hFFFF);
    send_pkt(0, sp, -1);
    quiet_count(20, cnt);
    check_val("pre_tik_quiet", 64'(cnt), 64'd0);
    tik_step();
    recv_pkt(0, -1, got);
    check_val("fwd_E", 64'(got), 64'({sp[59:16], 16'h1234}));
    $display("txn: spike idx3 via E -> %h", got);

    // Disabled entry: nothing ever leaves.
    send_pkt(0, cfg_pkt(4'd5, 1'b0, 2'd1, 16'hAAAA), -1);
    send_pkt(1, spike_pkt(4'd5, 38'h01_0203_0405, 16'h0), -1);
    tik_step();
    tik_step();
    quiet_count(30, cnt);
    check_val("disabled_quiet", 64'(cnt), 64'd0);
    $display("txn: spike to disabled entry, emitted=%0d", cnt);

    // Corrupt f1: err flagged on that flit only, packet dropped, next good one passes.
    send_pkt(0, spike_pkt(4'd3, 38'h3F_0000_1111, 16'h5555), 1);
    tik_step();
    quiet_count(30, cnt);
    check_val("bad_par_dropped", 64'(cnt), 64'd0);
    sp2 = spike_pkt(4'd3, 38'h2A_BCDE_F012, 16'h0001);
    send_pkt(0, sp2, -1);
    tik_step();
    recv_pkt(0, -1, got);
    check_val("after_bad_fwd", 64'(got), 64'({sp2[59:16], 16'h1234}));
    $display("txn: good spike after bad parity -> %h", got);

    // Peer error on f2: f2 resent, packet intact.
    sp = spike_pkt(4'd3, 38'h15_5555_AAAA, 16'h7777);
    send_pkt(0, sp, -1);
    tik_step();
    recv_pkt(0, 2, got);
    check_val("resend_fwd", 64'(got), 64'({sp[59:16], 16'h1234}));
    $display("txn: spike with peer err on f2 -> %h", got);

    // Five spikes to N before any edge: fifth is held in the W receiver.
    send_pkt(0, cfg_pkt(4'd7, 1'b1, 2'd1, 16'hBEEF), -1);
    for (int i = 0; i < 5; i++) begin
      five[i] = spike_pkt(4'd7, 38'(64'h10_0000_0000 + i), 16'(i));
      send_pkt(2, five[i], -1);
    end
    in_data[2] = 16'h0; in_par[2] = 1'b0; in_valid[2] = 1'b1;
    repeat (8) @(negedge clk);
    check_val("backpressure_stall", 64'(in_ready[2]), 64'd0);
    in_valid[2] = 1'b0;
    @(negedge clk);
    tik_step();
    for (int i = 0; i < 4; i++) begin
      recv_pkt(1, -1, got);
      check_val($sformatf("fifo_N_%0d", i), 64'(got), 64'({five[i][59:16], 16'hBEEF}));
      $display("txn: N drain %0d -> %h", i, got);
    end
    quiet_count(10, cnt);
    check_val("fifth_waits_edge", 64'(cnt), 64'd0);
    tik_step();
    recv_pkt(1, -1, got);
    check_val("fifo_N_4", 64'(got), 64'({five[4][59:16], 16'hBEEF}));
    $display("txn: N drain 4 -> %h", got);

    // Concurrent E and W spikes to S: both forwarded once each.
    send_pkt(0, cfg_pkt(4'd8, 1'b1, 2'd3, 16'h0A0A), -1);
    send_pkt(0, cfg_pkt(4'd9, 1'b1, 2'd3, 16'h0B0B), -1);
    pa = spike_pkt(4'd8, 38'h00_1111_2222, 16'h0);
    pb = spike_pkt(4'd9, 38'h00_3333_4444, 16'h0);
    fork
      send_pkt(0, pa, -1);
      send_pkt(2, pb, -1);
    join
    tik_step();
    recv_pkt(3, -1, got);
    recv_pkt(3, -1, got2);
    check_val("rr_first_known",
              64'((got == {pa[59:16], 16'h0A0A}) || (got == {pb[59:16], 16'h0B0B})), 64'd1);
    check_val("rr_second_other", 64'(got2),
              (got == {pa[59:16], 16'h0A0A}) ? 64'({pb[59:16], 16'h0B0B}) : 64'({pa[59:16], 16'h0A0A}));
    $display("txn: concurrent E/W to S -> %h then %h", got, got2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
